// File: rtl/cart_motor_pwm.sv
// rtl/cart_motor_pwm.sv - signed motor command to slew-limited, dead-timed H-bridge PWM
//
// Purpose:
//   Converts the balance controller's signed command into one PWM line and one
//   direction line. Duty changes by at most SLEW_STEP per PWM period. A reversal
//   first ramps the duty to zero, then holds the output low for DEADTIME periods
//   before flipping direction. If no command arrives for TIMEOUT_PERIODS periods,
//   the target is forced to zero and the motor ramps down.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-low reset
//   enable       - 1 = drive allowed, 0 = stop on the next edge
//   cmd_valid    - one-cycle strobe qualifying cmd
//   cmd          - signed command (>0 forward, <0 reverse)
//   pwm_out      - H-bridge PWM
//   motor_dir    - 0 = forward, 1 = reverse
//   duty_applied - applied duty magnitude (high cycles per period)
//   dead_active  - 1 while in the dead period
//   timeout      - watchdog expired, sticky until the next cmd_valid

module cart_motor_pwm #(
  parameter int CMD_W           = 8,
  parameter int SLEW_STEP       = 4,
  parameter int DEADTIME        = 2,
  parameter int TIMEOUT_PERIODS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd,
  output logic             pwm_out,
  output logic             motor_dir,
  output logic [CMD_W-2:0] duty_applied,
  output logic             dead_active,
  output logic             timeout
);

  localparam int DW     = CMD_W - 1;
  localparam int STEP_I = (SLEW_STEP > (2**DW) - 1) ? (2**DW) - 1 : SLEW_STEP;
  localparam logic [DW-1:0] STEP = DW'(STEP_I);
  localparam int DCW = $clog2(DEADTIME + 1);
  localparam int WDW = $clog2(TIMEOUT_PERIODS + 1);
  localparam logic [CMD_W-1:0] CMD_MIN = {1'b1, {DW{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DEAD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [CMD_W-1:0] target_q, target_d;
  logic [DW-1:0]    duty_q, duty_d;
  logic             dir_q, dir_d;
  logic [DCW-1:0]   dead_cnt_q, dead_cnt_d;
  logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;

  logic             boundary;
  logic             tgt_neg;
  logic             tgt_zero;
  logic [DW-1:0]    tgt_mag;
  logic [DW-1:0]    goal;
  logic [DW-1:0]    duty_step;
  logic [CMD_W-1:0] cmd_sat;

  always_comb begin
    boundary = (cnt_q == '1);
    tgt_neg  = target_q[CMD_W-1];
    tgt_zero = (target_q == '0);
    // Target is never the most negative code, so the magnitude fits in DW bits.
    tgt_mag  = tgt_neg ? (~target_q[DW-1:0] + DW'(1)) : target_q[DW-1:0];
    // The most negative command has no positive twin; clamp it one code inward.
    cmd_sat  = (cmd == CMD_MIN) ? (CMD_MIN | CMD_W'(1)) : cmd;

    // Drive only toward a target on the current side; otherwise ramp to zero.
    goal = (!tgt_zero && (tgt_neg == dir_q)) ? tgt_mag : '0;
    if (duty_q < goal) begin
      duty_step = ((goal - duty_q) > STEP) ? duty_q + STEP : goal;
    end else begin
      duty_step = ((duty_q - goal) > STEP) ? duty_q - STEP : goal;
    end

    cnt_d      = cnt_q + DW'(1);
    target_d   = target_q;
    wd_cnt_d   = wd_cnt_q;
    timeout_d  = timeout_q;
    state_d    = state_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    dead_cnt_d = dead_cnt_q;

    // A fresh command always beats watchdog expiry in the same cycle.
    if (cmd_valid) begin
      target_d  = cmd_sat;
      wd_cnt_d  = '0;
      timeout_d = 1'b0;
    end else if (boundary && !timeout_q) begin
      if (wd_cnt_q == WDW'(TIMEOUT_PERIODS - 1)) begin
        timeout_d = 1'b1;
        target_d  = '0;
        wd_cnt_d  = WDW'(TIMEOUT_PERIODS);
      end else begin
        wd_cnt_d = wd_cnt_q + WDW'(1);
      end
    end

    if (!enable) begin
      state_d    = ST_IDLE;
      duty_d     = '0;
      dead_cnt_d = '0;
    end else if (boundary) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!tgt_zero) begin
            if (tgt_neg == dir_q) begin
              state_d = ST_DRIVE;
              duty_d  = duty_step;
            end else begin
              state_d    = ST_DEAD;
              dead_cnt_d = DCW'(DEADTIME);
            end
          end
        end
        ST_DRIVE: begin
          duty_d = duty_step;
          if (duty_step == '0) begin
            state_d = ST_IDLE;
          end
        end
        ST_DEAD: begin
          if (dead_cnt_q <= DCW'(1)) begin
            dead_cnt_d = '0;
            dir_d      = ~dir_q;
            state_d    = ST_IDLE;
          end else begin
            dead_cnt_d = dead_cnt_q - DCW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      target_q   <= '0;
      duty_q     <= '0;
      dir_q      <= 1'b0;
      dead_cnt_q <= '0;
      wd_cnt_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      dead_cnt_q <= dead_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Decoded from registers only so the bridge never sees a combinational glitch path from inputs.
  assign pwm_out      = (state_q == ST_DRIVE) && (cnt_q < duty_q);
  assign motor_dir    = dir_q;
  assign duty_applied = duty_q;
  assign dead_active  = (state_q == ST_DEAD);
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_cart_motor_pwm.sv
// tb/tb_cart_motor_pwm.sv - directed self-checking bench for cart_motor_pwm

module tb_cart_motor_pwm;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic       pwm_out;
  logic       motor_dir;
  logic [6:0] duty_applied;
  logic       dead_active;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int hi;
  int e;

  cart_motor_pwm #(
    .CMD_W(8), .SLEW_STEP(4), .DEADTIME(2), .TIMEOUT_PERIODS(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd(cmd),
    .pwm_out(pwm_out), .motor_dir(motor_dir), .duty_applied(duty_applied),
    .dead_active(dead_active), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic goto_boundary();
    do step(); while (k % 128 != 0);
  endtask

  task automatic goto_cnt(input int c);
    do step(); while (k % 128 != c);
  endtask

  task automatic send_cmd(input logic [7:0] v);
    cmd = v;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic measure(output int h);
    h = 0;
    repeat (128) begin
      if (pwm_out) h++;
      step();
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    k = 0;
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b1;
    cmd_valid = 1'b0;
    cmd = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", pwm_out, 0);
    check("rst_dir", motor_dir, 0);
    check("rst_duty", duty_applied, 0);
    check("rst_dead", dead_active, 0);
    check("rst_timeout", timeout, 0);
    release_reset();

    // +20 from IDLE: 4,8,12,16,20 then steady, 20 high cycles per period
    send_cmd(8'd20);
    for (int i = 1; i <= 5; i++) begin
      goto_boundary();
      check($sformatf("ramp20_duty_%0d", i), duty_applied, 4 * i);
      check("ramp20_dir", motor_dir, 0);
    end
    goto_boundary();
    check("ramp20_steady", duty_applied, 20);
    measure(hi);
    check("ramp20_high_cycles", hi, 20);

    // down to +8, then reverse to -8 through DEAD
    send_cmd(8'd8);
    goto_boundary(); check("down8_a", duty_applied, 16);
    goto_boundary(); check("down8_b", duty_applied, 12);
    goto_boundary(); check("down8_c", duty_applied, 8);
    goto_boundary(); check("down8_steady", duty_applied, 8);
    send_cmd(8'hF8);
    goto_boundary(); check("rev_duty4", duty_applied, 4);
    goto_boundary(); check("rev_duty0", duty_applied, 0);
    check("rev_idle_dead", dead_active, 0);
    goto_boundary();
    check("rev_dead_enter", dead_active, 1);
    check("rev_dead_dir", motor_dir, 0);
    measure(hi);
    check("rev_dead_pwm_low", hi, 0);
    check("rev_dead_second", dead_active, 1);
    check("rev_dead_dir2", motor_dir, 0);
    goto_boundary();
    check("rev_exit_dead", dead_active, 0);
    check("rev_exit_dir", motor_dir, 1);
    check("rev_exit_duty", duty_applied, 0);
    goto_boundary(); check("rev_duty_a", duty_applied, 4);
    goto_boundary(); check("rev_duty_b", duty_applied, 8);

    // -128 saturates to -127: ramp to 124 then 127, never a full period high
    send_cmd(8'h80);
    e = 8;
    while (e < 127) begin
      e = (e + 4 > 127) ? 127 : e + 4;
      goto_boundary();
      check("sat_ramp_duty", duty_applied, e);
      check("sat_ramp_dir", motor_dir, 1);
      send_cmd(8'h80);
    end
    goto_boundary();
    check("sat_steady", duty_applied, 127);
    measure(hi);
    check("sat_high_cycles", hi, 127);

    // async reset mid-DRIVE at duty 40
    reset = 1'b0;
    step();
    release_reset();
    send_cmd(8'd40);
    repeat (10) goto_boundary();
    check("pre_rst_duty", duty_applied, 40);
    goto_cnt(5);
    check("pre_rst_pwm", pwm_out, 1);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_pwm", pwm_out, 0);
    check("async_rst_duty", duty_applied, 0);
    check("async_rst_dir", motor_dir, 0);
    check("async_rst_dead", dead_active, 0);
    check("async_rst_timeout", timeout, 0);
    release_reset();

    // +40 then silence: timeout at the 16th boundary, then ramp to 0
    send_cmd(8'd40);
    for (int b = 1; b <= 26; b++) begin
      goto_boundary();
      e = (b <= 10) ? 4 * b : (b <= 16) ? 40 : 40 - 4 * (b - 16);
      check($sformatf("wd_duty_b%0d", b), duty_applied, e);
      check($sformatf("wd_timeout_b%0d", b), timeout, (b >= 16) ? 1 : 0);
    end
    goto_cnt(50);
    check("wd_sticky", timeout, 1);
    send_cmd(8'hF4);
    check("wd_clear", timeout, 0);

    // enable=0 while DEAD with one period left
    goto_boundary(); check("en_dead_a", dead_active, 1);
    goto_boundary(); check("en_dead_b", dead_active, 1);
    goto_cnt(20);
    enable = 1'b0;
    step();
    check("en_off_dead", dead_active, 0);
    check("en_off_dir", motor_dir, 0);
    check("en_off_duty", duty_applied, 0);
    check("en_off_pwm", pwm_out, 0);
    goto_boundary();
    check("en_off_boundary_dead", dead_active, 0);
    check("en_off_boundary_dir", motor_dir, 0);
    goto_cnt(30);
    enable = 1'b1;
    goto_boundary(); check("en_on_dead", dead_active, 1);
    goto_boundary(); check("en_on_dead2", dead_active, 1);
    goto_boundary();
    check("en_on_exit", dead_active, 0);
    check("en_on_dir", motor_dir, 1);
    goto_boundary(); check("en_on_duty4", duty_applied, 4);
    goto_boundary(); check("en_on_duty8", duty_applied, 8);
    goto_boundary(); check("en_on_duty12", duty_applied, 12);

    // cmd_valid on the boundary cycle takes effect one period later
    goto_cnt(127);
    cmd = 8'hEC;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("bnd_cmd_hold", duty_applied, 12);
    goto_boundary(); check("bnd_cmd_next", duty_applied, 16);
    goto_boundary(); check("bnd_cmd_final", duty_applied, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
